// File: rtl/rpu_pkg.sv
// ============================================================================
// rpu_pkg : shared widths and the AER event record for the spike pipeline
// Rev 1.0
// ============================================================================
`default_nettype none

package rpu_pkg;

    localparam int AER_NUM_NEURONS = 16;
    localparam int AER_ADDR_W      = 4;
    localparam int AER_TS_W        = 16;
    localparam int AER_FIFO_DEPTH  = 8;
    localparam int DROP_CNT_W      = 8;

    typedef struct packed {
        logic [AER_ADDR_W-1:0] addr;
        logic [AER_TS_W-1:0]   ts;
    } aer_event_t;

endpackage

`default_nettype wire

// File: rtl/aer_fifo.sv
// ============================================================================
// aer_fifo : first-word-fall-through event queue, wrap-bit pointers
// Rev 1.0
// ============================================================================
`default_nettype none

module aer_fifo
    import rpu_pkg::*;
#(
    parameter int DEPTH = AER_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  aer_event_t push_data,
    input  logic       pop,
    output aer_event_t head,
    output logic       full,
    output logic       empty
);

    localparam int PTR_W = $clog2(DEPTH);

    aer_event_t       r_mem [DEPTH];
    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;
    logic             w_push_en;
    logic             w_pop_en;

    // Extra MSB distinguishes full from empty when the index bits match.
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);

    assign w_push_en = push && !full;
    assign w_pop_en  = pop && !empty;

    assign head = empty ? '0 : r_mem[r_rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (w_push_en) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_en)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/aer_spike_encoder.sv
// ============================================================================
// aer_spike_encoder : round-robin AER encoder with timestamps and drop count
// Rev 1.0
// ============================================================================
`default_nettype none

module aer_spike_encoder
    import rpu_pkg::*;
#(
    parameter int NUM_NEURONS = AER_NUM_NEURONS,
    parameter int ADDR_W      = AER_ADDR_W,
    parameter int TS_W        = AER_TS_W,
    parameter int FIFO_DEPTH  = AER_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_NEURONS-1:0] spike_in,
    input  logic                   drop_clr,
    output logic                   aer_valid,
    input  logic                   aer_ready,
    output logic [ADDR_W-1:0]      aer_addr,
    output logic [TS_W-1:0]        aer_ts,
    output logic [DROP_CNT_W-1:0]  drop_count
);

    localparam int SUM_W = DROP_CNT_W + ADDR_W + 1;

    logic [NUM_NEURONS-1:0] r_pending;
    logic [ADDR_W-1:0]      r_last_grant;
    logic [TS_W-1:0]        r_ts;
    logic [DROP_CNT_W-1:0]  r_drop_count;

    logic                   w_grant_valid;
    logic [ADDR_W-1:0]      w_grant_idx;
    logic [NUM_NEURONS-1:0] w_grant_vec;
    logic [NUM_NEURONS-1:0] w_drop_vec;
    logic [ADDR_W:0]        w_drop_num;
    logic [SUM_W-1:0]       w_drop_sum;
    logic                   w_full;
    logic                   w_empty;
    aer_event_t             w_push_data;
    aer_event_t             w_head;

    // Search starts one past the last grant; a full queue suppresses the grant.
    always_comb begin
        logic [ADDR_W:0] cand;
        cand          = '0;
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        w_grant_vec   = '0;
        if (!w_full) begin
            for (int off = 1; off <= NUM_NEURONS; off++) begin
                cand = {1'b0, r_last_grant} + (ADDR_W+1)'(off);
                if (cand >= (ADDR_W+1)'(NUM_NEURONS)) begin
                    cand = cand - (ADDR_W+1)'(NUM_NEURONS);
                end
                if (!w_grant_valid && r_pending[cand[ADDR_W-1:0]]) begin
                    w_grant_valid = 1'b1;
                    w_grant_idx   = cand[ADDR_W-1:0];
                end
            end
        end
        if (w_grant_valid) begin
            w_grant_vec[w_grant_idx] = 1'b1;
        end
    end

    // A re-fire on an already pending, ungranted neuron is coalesced.
    assign w_drop_vec = spike_in & r_pending & ~w_grant_vec;

    always_comb begin
        w_drop_num = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            w_drop_num = w_drop_num + (ADDR_W+1)'(w_drop_vec[i]);
        end
    end

    assign w_drop_sum = SUM_W'(r_drop_count) + SUM_W'(w_drop_num);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending    <= '0;
            r_last_grant <= ADDR_W'(NUM_NEURONS - 1);
            r_ts         <= '0;
            r_drop_count <= '0;
        end else begin
            r_pending <= (r_pending & ~w_grant_vec) | spike_in;
            r_ts      <= r_ts + 1'b1;
            if (w_grant_valid) begin
                r_last_grant <= w_grant_idx;
            end
            if (drop_clr) begin
                r_drop_count <= '0;
            end else if (w_drop_sum > SUM_W'({DROP_CNT_W{1'b1}})) begin
                r_drop_count <= {DROP_CNT_W{1'b1}};
            end else begin
                r_drop_count <= w_drop_sum[DROP_CNT_W-1:0];
            end
        end
    end

    always_comb begin
        w_push_data      = '0;
        w_push_data.addr = w_grant_idx;
        w_push_data.ts   = r_ts;
    end

    aer_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_aer_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_grant_valid),
        .push_data (w_push_data),
        .pop       (aer_valid && aer_ready),
        .head      (w_head),
        .full      (w_full),
        .empty     (w_empty)
    );

    assign aer_valid  = !w_empty;
    assign aer_addr   = w_head.addr;
    assign aer_ts     = w_head.ts;
    assign drop_count = r_drop_count;

endmodule

`default_nettype wire

// File: tb/tb_aer_spike_encoder.sv
// ============================================================================
// tb_aer_spike_encoder : directed stimulus with a queue-based event scoreboard
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_aer_spike_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] spike_in = '0;
    logic        drop_clr = 1'b0;
    logic        aer_valid;
    logic        aer_ready = 1'b0;
    logic [3:0]  aer_addr;
    logic [15:0] aer_ts;
    logic [7:0]  drop_count;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] ts;
    } exp_t;
    exp_t exp_q[$];

    aer_spike_encoder dut (
        .clk        (clk),
        .rst        (rst),
        .spike_in   (spike_in),
        .drop_clr   (drop_clr),
        .aer_valid  (aer_valid),
        .aer_ready  (aer_ready),
        .aer_addr   (aer_addr),
        .aer_ts     (aer_ts),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    // Cycle index since reset release; equals the DUT timestamp in that cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cyc %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) tick();
    endtask

    task automatic pulse(input logic [15:0] mask);
        spike_in = mask;
        tick();
        spike_in = '0;
    endtask

    task automatic expect_ev(input int a, input int t);
        exp_t e;
        e.addr = 4'(a);
        e.ts   = 16'(t);
        exp_q.push_back(e);
    endtask

    task automatic wait_empty(input int bound);
        for (int i = 0; i < bound && exp_q.size() != 0; i++) tick();
        chk("queue_drained", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        spike_in = '0;
        drop_clr = 1'b0;
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && aer_valid && aer_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_event: got addr=%0d ts=%0h, required none", aer_addr, aer_ts);
            end else begin
                e = exp_q.pop_front();
                chk("event_addr", aer_addr, e.addr);
                chk("event_ts", aer_ts, e.ts);
            end
        end
    end

    initial begin
        // Reset state
        tick();
        @(negedge clk);
        chk("rst_valid", aer_valid, 0);
        chk("rst_addr", aer_addr, 0);
        chk("rst_ts", aer_ts, 0);
        chk("rst_drop", drop_count, 0);
        tick();
        rst = 1'b0;

        // Single spike: two-cycle latency, ts of grant cycle
        aer_ready = 1'b1;
        wait_cyc(5);
        expect_ev(3, 6);
        pulse(16'h0008);
        @(negedge clk);
        chk("lat_not_yet", aer_valid, 0);
        tick();
        @(negedge clk);
        chk("lat_valid", aer_valid, 1);
        wait_empty(16);

        // Simultaneous spikes on 0 and 15
        do_reset();
        aer_ready = 1'b1;
        wait_cyc(1);
        expect_ev(0, 2);
        expect_ev(15, 3);
        pulse(16'h8001);
        wait_empty(16);

        // Backpressure: 8 queued, 8 held pending, push blocked on the pop cycle
        do_reset();
        aer_ready = 1'b0;
        wait_cyc(1);
        for (int k = 0; k < 8; k++) expect_ev(k, 2 + k);
        pulse(16'hFFFF);
        wait_cyc(12);
        @(negedge clk);
        chk("bp_valid", aer_valid, 1);
        chk("bp_addr", aer_addr, 0);
        chk("bp_ts", aer_ts, 2);
        tick();
        @(negedge clk);
        chk("bp_addr_stable", aer_addr, 0);
        chk("bp_ts_stable", aer_ts, 2);
        tick();
        aer_ready = 1'b1;
        for (int k = 8; k < 16; k++) expect_ev(k, 15 + (k - 8));
        wait_empty(64);
        chk("bp_no_drops", drop_count, 0);

        // Coalescing, clear priority and saturation
        do_reset();
        aer_ready = 1'b0;
        wait_cyc(1);
        for (int k = 0; k < 8; k++) expect_ev(k, 2 + k);
        pulse(16'h00FF);
        wait_cyc(12);
        pulse(16'h0004);
        wait_cyc(14);
        pulse(16'h0004);
        wait_cyc(16);
        pulse(16'h0004);
        wait_cyc(18);
        @(negedge clk);
        chk("coal_drop2", drop_count, 2);
        tick();
        drop_clr = 1'b1;
        spike_in = 16'h0004;
        tick();
        drop_clr = 1'b0;
        spike_in = '0;
        @(negedge clk);
        chk("coal_clr_priority", drop_count, 0);
        tick();
        spike_in = 16'h0004;
        repeat (300) tick();
        spike_in = '0;
        @(negedge clk);
        chk("coal_saturate", drop_count, 255);
        tick();
        aer_ready = 1'b1;
        expect_ev(2, cyc + 1);
        wait_empty(64);
        chk("coal_sat_held", drop_count, 255);

        // Fairness between 1 and 9, then timestamp wrap
        do_reset();
        aer_ready = 1'b1;
        wait_cyc(1);
        for (int k = 0; k < 9; k++) expect_ev((k % 2 == 0) ? 1 : 9, 2 + k);
        spike_in = 16'h0202;
        repeat (8) tick();
        spike_in = '0;
        wait_empty(32);
        chk("fair_drops", drop_count, 7);
        wait_cyc(65534);
        expect_ev(9, 16'hFFFF);
        expect_ev(1, 0);
        pulse(16'h0202);
        wait_empty(16);

        // Reset mid-stream discards queued events, neuron 0 first afterwards
        do_reset();
        aer_ready = 1'b0;
        wait_cyc(1);
        pulse(16'h001F);
        wait_cyc(8);
        @(negedge clk);
        chk("mid_valid_before", aer_valid, 1);
        tick();
        rst = 1'b1;
        #1;
        chk("mid_valid_async", aer_valid, 0);
        chk("mid_addr_async", aer_addr, 0);
        tick();
        tick();
        rst = 1'b0;
        aer_ready = 1'b1;
        wait_cyc(2);
        expect_ev(0, 3);
        expect_ev(5, 4);
        expect_ev(15, 5);
        pulse(16'h8021);
        wait_empty(32);
        repeat (3) tick();
        @(negedge clk);
        chk("final_idle", aer_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/aer_spike_encoder.md
AER_SPIKE_ENCODER -- requirements
Module: aer_spike_encoder

Interface
REQ-001 SHALL have parameter NUM_NEURONS, default 16: number of neuron_core spike_out lines collected.
REQ-002 SHALL have parameter ADDR_W, default 4: event address width, equal to clog2(NUM_NEURONS).
REQ-003 SHALL have parameter TS_W, default 16: timestamp width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 8, power of two: event queue depth.
REQ-005 SHALL have port clk  in  1  clock, all state on rising edge.
REQ-006 SHALL have port rst  in  1  reset; asynchronous, active-high.
REQ-007 SHALL have port spike_in  in  NUM_NEURONS  one-cycle fire pulses, bit i from neuron_core i.
REQ-008 SHALL have port drop_clr  in  1  synchronous clear of drop_count.
REQ-009 SHALL have port aer_valid  out  1  event available.
REQ-010 SHALL have port aer_ready  in  1  consumer accepts event.
REQ-011 SHALL have port aer_addr  out  ADDR_W  index of the firing neuron.
REQ-012 SHALL have port aer_ts  out  TS_W  timestamp of the event.
REQ-013 SHALL have port drop_count  out  8  coalesced spikes, saturating.

Function
REQ-014 SHALL keep a pending bit per neuron, set at the edge following spike_in[i]=1.
REQ-015 SHALL keep a free-running ts counter, +1 every cycle, modulo 2^TS_W wrap.
REQ-016 SHALL grant at most one pending neuron per cycle, round-robin: search starts at last_grant+1, wraps at NUM_NEURONS-1 to 0.
REQ-017 SHALL grant only when FIFO not full; a grant pushes {index, ts value of the grant cycle} and clears that pending bit at the same edge.
REQ-018 SHALL, when FIFO full, grant nothing and leave pending bits and last_grant unchanged; a push is blocked when full even if a pop occurs in the same cycle.
REQ-019 SHALL, when spike_in[i]=1 in the cycle neuron i is granted, leave pending[i] set (new event, not a drop).
REQ-020 SHALL, when spike_in[i]=1 while pending[i]=1 and i not granted that cycle, keep pending[i] and increment drop_count by 1 per such bit, saturating at 255.
REQ-021 SHALL give drop_clr priority over increments in the same cycle; the count becomes 0.
REQ-022 SHALL present FIFO head first-word-fall-through: aer_valid = not empty; aer_addr/aer_ts stable while aer_valid=1 and aer_ready=0.
REQ-023 SHALL pop on aer_valid and aer_ready; aer_ready while empty has no effect.
REQ-024 SHALL have minimum latency 2 cycles: spike_in high in cycle t gives aer_valid high in cycle t+2 with an idle empty FIFO.
REQ-025 SHALL sustain one event per cycle when pending and aer_ready are continuously high.

Reset
REQ-026 SHALL clear on rst: pending=0, FIFO empty, aer_valid=0, aer_addr=0, aer_ts=0, ts=0, drop_count=0.
REQ-027 SHALL set last_grant=NUM_NEURONS-1 on reset so neuron 0 has first priority.
REQ-028 SHALL discard queued and pending events on rst asserted mid-operation; aer_valid falls asynchronously.

Structure
REQ-029 SHALL take default widths and the event record type {addr, ts} from shared package rpu_pkg.
REQ-030 SHALL instantiate one sub-module aer_fifo: synchronous FWFT FIFO with full/empty flags, wrap-around read/write pointers, asynchronous reset.
REQ-031 SHALL keep the round-robin arbiter, pending register and drop counter in aer_spike_encoder.

Verification
REQ-032 Single spike: spike_in=16'h0008 at cycle 5 (ts=5), aer_ready=1 -> aer_valid in cycle 7, aer_addr=3, aer_ts=6.
REQ-033 Simultaneous: spike_in=16'h8001 one cycle after reset -> events addr 0 then 15 on consecutive cycles, ts differing by 1.
REQ-034 Backpressure: aer_ready=0, spike_in=16'hFFFF for 1 cycle -> 8 events queued (addr 0..7), pending 8..15 held, aer_valid=1 with outputs stable; then aer_ready=1 -> addr 0..15 in order, no drops.
REQ-035 Coalesce: aer_ready=0, FIFO full, spike_in[2] pulsed 3 times -> drop_count=2 and one addr 2 event; drop_clr -> 0; 300 coalesced pulses -> drop_count=255.
REQ-036 Fairness: neurons 1 and 9 pulsed every cycle -> grants alternate 1,9,1,9; ts counter wraps 16'hFFFF -> 0 with events unaffected.
REQ-037 Reset mid-stream: rst with 5 queued events -> aer_valid=0 immediately; after release the first spike on neuron 0 is granted before others.
